// File: rtl/mmio_console_uart.sv
// mmio_console_uart
//   Console and halt peripheral snooping the core's DCCM store port.
//   Stores to CONSOLE_ADDR push wdata[7:0] into a byte FIFO that is
//   serialised on uart_tx (8N1, or 8E1 when UART_PARITY_EN is defined).
//   The first store to HALT_ADDR latches its data as halt_code and arms a
//   halt request.
//   halt_req is raised once every queued console byte has left the line.
//   It then stays set until reset.
//
//   Optional feature macro: UART_PARITY_EN (adds an even-parity bit per frame).
//
// Ports
//   clk         in   clock
//   rstn        in   synchronous active-low reset
//   dccm_wen    in   store strobe, one cycle per store
//   dccm_waddr  in   store address (full-width compare)
//   dccm_wdata  in   store data
//   uart_tx     out  serial line, idle high
//   tx_busy     out  FIFO non-empty or transmitter not idle
//   fifo_count  out  FIFO occupancy
//   drop_count  out  bytes lost to a full FIFO, saturating
//   halt_req    out  sticky halt request
//   halt_code   out  data of the first halt store
//
// TX FSM
//   state    | meaning
//   S_IDLE   | line high; pops the FIFO head when one is available
//   S_START  | start bit (0) for CLKS_PER_BIT cycles
//   S_DATA   | 8 data bits, LSB first, one per baud period
//   S_PARITY | even parity bit (only with UART_PARITY_EN)
//   S_STOP   | stop bit (1) for CLKS_PER_BIT cycles
module mmio_console_uart #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = 32'h0020_0000,
  parameter logic [XLEN-1:0] HALT_ADDR    = 32'h1000_0000,
  parameter int              CLKS_PER_BIT = 868,
  parameter int              FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          dccm_wen,
  input  logic [XLEN-1:0]               dccm_waddr,
  input  logic [XLEN-1:0]               dccm_wdata,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic                          halt_req,
  output logic [XLEN-1:0]               halt_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  // Elaboration-time configuration checks.
  generate
    if (CONSOLE_ADDR == HALT_ADDR) begin : g_bad_addr
      $error("mmio_console_uart: CONSOLE_ADDR and HALT_ADDR must differ");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("mmio_console_uart: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("mmio_console_uart: FIFO_DEPTH must be a power of 2, at least 2");
    end
  endgenerate

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  // Store decode
  logic push, halt_store;
  assign push       = dccm_wen & (dccm_waddr == CONSOLE_ADDR);
  assign halt_store = dccm_wen & (dccm_waddr == HALT_ADDR);

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   drop_q;
  logic          pop, accept, drop;

  // A pop on the same edge frees a slot, so a push into a full FIFO is kept.
  assign accept = push & ((count_q != FIFO_FULL) | pop);
  assign drop   = push & ~accept;

  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      mem_q[wptr_q] <= dccm_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // TX FSM
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_done;
`ifdef UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign baud_done = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // tx_d is the line level belonging to the current state; registering it
  // delays the line by one cycle, so the start bit appears two edges after
  // the push edge and the line is glitch-free.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    pop       = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = BAUD_LOAD;
          state_d = S_START;
`ifdef UART_PARITY_EN
          parity_d = ^mem_q[rptr_q];
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Halt
  logic            halt_pending_q;
  logic            halt_req_q;
  logic [XLEN-1:0] halt_code_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      halt_pending_q <= 1'b0;
      halt_req_q     <= 1'b0;
      halt_code_q    <= '0;
    end else begin
      if (halt_store && !halt_pending_q) begin
        halt_pending_q <= 1'b1;
        halt_code_q    <= dccm_wdata;
      end
      // A console push in the same cycle still has to drain first.
      if (halt_pending_q && (count_q == '0) && (state_q == S_IDLE) && !push) begin
        halt_req_q <= 1'b1;
      end
    end
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = (count_q != '0) | (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign drop_count = drop_q;
  assign halt_req   = halt_req_q;
  assign halt_code  = halt_code_q;

endmodule

// File: tb/tb_mmio_console_uart.sv
// Bench for mmio_console_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-based reference model predicts every output each cycle; directed
// scenarios add literal expectations for latency, frame bits, drops and halt.
module tb_mmio_console_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] CONS = 32'h0020_0000;
  localparam logic [31:0] HALT = 32'h1000_0000;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        uart_tx, tx_busy, halt_req;
  logic [2:0]  fifo_count;
  logic [15:0] drop_count;
  logic [31:0] halt_code;

  always #5 clk = ~clk;

  mmio_console_uart #(
    .XLEN(32), .CONSOLE_ADDR(CONS), .HALT_ADDR(HALT),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .dccm_wen(wen), .dccm_waddr(waddr), .dccm_wdata(wdata),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .drop_count(drop_count), .halt_req(halt_req), .halt_code(halt_code)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the line as a queue of per-cycle levels.
  logic [7:0]  mq[$];
  bit          lineq[$];
  int          busy_left = 0;
  int          drops = 0;
  bit          hpend = 0, hreq = 0;
  logic [31:0] hcode = '0;
  logic        e_tx = 1'b1;
  bit          started = 0;

  initial begin : model
    bit         m_push, m_hst, m_pop;
    int         pre;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        mq.delete(); lineq.delete();
        busy_left = 0; drops = 0; hpend = 0; hreq = 0; hcode = '0; e_tx = 1'b1;
      end else begin
        m_push = (wen === 1'b1) && (waddr == CONS);
        m_hst  = (wen === 1'b1) && (waddr == HALT);
        pre    = mq.size();
        m_pop  = (busy_left == 0) && (pre > 0);
        if (hpend && pre == 0 && busy_left == 0 && !m_push) hreq = 1;
        if (m_hst && !hpend) begin hpend = 1; hcode = wdata; end
        e_tx = (lineq.size() != 0) ? lineq.pop_front() : 1'b1;
        if (busy_left > 0) busy_left--;
        if (m_pop) begin
          b = mq.pop_front();
          for (int k = 0; k < CPB; k++) lineq.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int k = 0; k < CPB; k++) lineq.push_back(b[i]);
`ifdef UART_PARITY_EN
          for (int k = 0; k < CPB; k++) lineq.push_back(^b);
`endif
          for (int k = 0; k < CPB; k++) lineq.push_back(1'b1);
          busy_left = NBITS * CPB;
        end
        if (m_push) begin
          if (pre < DEPTH || m_pop) mq.push_back(wdata[7:0]);
          else if (drops < 65535) drops++;
        end
      end
      started = 1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_uart_tx",    32'(uart_tx),    32'(e_tx));
        chk("m_tx_busy",    32'(tx_busy),    32'(mq.size() != 0 || busy_left != 0));
        chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("m_drop_count", 32'(drop_count), 32'(drops));
        chk("m_halt_req",   32'(halt_req),   32'(hreq));
        chk("m_halt_code",  halt_code,       hcode);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic release_bus();
    wen = 1'b0; waddr = '0; wdata = '0;
  endtask

  // Waits for a start bit, then samples each bit in the middle of its period.
  task automatic rx_byte(output logic [7:0] b, output logic par, output logic ok);
    int n;
    b = '0; par = 1'b0; ok = 1'b0; n = 0;
    while (uart_tx !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? CPB + 1 : CPB) @(negedge clk);
      b[i] = uart_tx;
    end
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    par = uart_tx;
`endif
    repeat (CPB) @(negedge clk);
    ok = (uart_tx === 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk(name, 32'(tx_busy), 32'd0);
  endtask

  initial begin : main
    logic [7:0]  rb;
    logic        rpar, rok;
    logic [10:0] got, exp_frame;

    release_bus();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx",    32'(uart_tx),    32'd1);
    chk("rst_tx_busy",    32'(tx_busy),    32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_halt_req",   32'(halt_req),   32'd0);
    chk("rst_halt_code",  halt_code,       32'd0);
    rstn = 1'b1;

    // Single byte 0x41: start bit two edges after the push edge.
    @(negedge clk); drive(CONS, 32'h0000_0041);
    @(negedge clk); release_bus();
    chk("s1_count_after_push", 32'(fifo_count), 32'd1);
    chk("s1_tx_high_p0", 32'(uart_tx), 32'd1);
    @(negedge clk);
    chk("s1_tx_high_p1", 32'(uart_tx), 32'd1);
    @(negedge clk);
    chk("s1_start_latency", 32'(uart_tx), 32'd0);
    got = '0;
    @(negedge clk); got[0] = uart_tx;
    for (int i = 1; i < NBITS; i++) begin
      repeat (CPB) @(negedge clk);
      got[i] = uart_tx;
    end
`ifdef UART_PARITY_EN
    exp_frame = 11'b1_0_01000001_0;
`else
    exp_frame = 11'b0_1_01000001_0;
`endif
    chk("s1_frame_bits", 32'(got), 32'(exp_frame));
    wait_idle("s1_idle");
    chk("s1_drop_count", 32'(drop_count), 32'd0);

    // Six back-to-back stores: 0x35 is dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk); drive(CONS, 32'h30 + 32'(i));
        end
        @(negedge clk); release_bus();
      end
      begin
        for (int j = 0; j < 5; j++) begin
          rx_byte(rb, rpar, rok);
          chk("s2_rx_ok", 32'(rok), 32'd1);
          chk("s2_rx_byte", 32'(rb), 32'h30 + 32'(j));
        end
      end
    join
    wait_idle("s2_idle");
    chk("s2_drop_count", 32'(drop_count), 32'd1);

    // Full FIFO with a push on the very edge the transmitter pops.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(CONS, 32'hA0 + 32'(i));
    end
    @(negedge clk); release_bus();
    repeat (NBITS * CPB - 3) @(negedge clk);
    chk("s4_full_before", 32'(fifo_count), 32'd4);
    drive(CONS, 32'h0000_00EE);
    @(negedge clk); release_bus();
    chk("s4_count_kept", 32'(fifo_count), 32'd4);
    chk("s4_drop_kept",  32'(drop_count), 32'd1);
    wait_idle("s4_idle");

    // Halt while bytes are queued.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(CONS, 32'h61 + 32'(i));
    end
    @(negedge clk); drive(HALT, 32'h0);
    @(negedge clk); release_bus();
    chk("s3_queued", 32'(fifo_count), 32'd3);
    chk("s3_halt_waits", 32'(halt_req), 32'd0);
    wait_idle("s3_idle");
    chk("s3_halt_low_at_idle", 32'(halt_req), 32'd0);
    @(negedge clk);
    chk("s3_halt_set",  32'(halt_req), 32'd1);
    chk("s3_halt_code", halt_code,     32'd0);
    drive(HALT, 32'h5);
    @(negedge clk); release_bus();
    @(negedge clk);
    chk("s3_halt_code_kept", halt_code,     32'd0);
    chk("s3_halt_sticky",    32'(halt_req), 32'd1);

    // Reset in the middle of the data bits of 0xAA.
    repeat (2) @(negedge clk);
    @(negedge clk); drive(CONS, 32'h0000_00AA);
    @(negedge clk); release_bus();
    repeat (9) @(negedge clk);
    chk("s5_busy_before_rst", 32'(tx_busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("s5_tx_high",   32'(uart_tx),    32'd1);
    chk("s5_count",     32'(fifo_count), 32'd0);
    chk("s5_drops",     32'(drop_count), 32'd0);
    chk("s5_halt_req",  32'(halt_req),   32'd0);
    chk("s5_halt_code", halt_code,       32'd0);
    chk("s5_busy",      32'(tx_busy),    32'd0);
    rstn = 1'b1;
    @(negedge clk); drive(CONS, 32'h0000_0055);
    @(negedge clk); release_bus();
    rx_byte(rb, rpar, rok);
    chk("s5_rx_ok",   32'(rok), 32'd1);
    chk("s5_rx_byte", 32'(rb),  32'h55);
    wait_idle("s5_idle");

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two.
    @(negedge clk); drive(CONS, 32'h0000_0007);
    @(negedge clk); release_bus();
    rx_byte(rb, rpar, rok);
    chk("s6_byte07", 32'(rb),   32'h07);
    chk("s6_par07",  32'(rpar), 32'd1);
    chk("s6_ok07",   32'(rok),  32'd1);
    wait_idle("s6_idle07");
    @(negedge clk); drive(CONS, 32'h0000_0003);
    @(negedge clk); release_bus();
    rx_byte(rb, rpar, rok);
    chk("s6_byte03", 32'(rb),   32'h03);
    chk("s6_par03",  32'(rpar), 32'd0);
    chk("s6_ok03",   32'(rok),  32'd1);
    wait_idle("s6_idle03");
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
